cdrom_link_responder: RTL and testbench

CDROM_LINK_RESPONDER -- requirements
Module: cdrom_link_responder

---
 rtl/cdrom_link_responder.sv | 164 ++++++++++++++++
 tb/tb_cdrom_link_responder.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdrom_link_responder.sv
// CD-ROM link responder: answers initiator byte strobes with status, FIFO data,
// FIFO count or flush acknowledgement, fed by a local producer through a byte FIFO.
module cdrom_link_responder #(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [3:0]               raspi_cmd,
  input  logic                     raspi_clk,
  input  logic                     raspi_en,
  output logic [7:0]               raspi_data,
  output logic                     raspi_ack,
  input  logic                     load_valid,
  input  logic [7:0]               load_data,
  output logic                     load_ready,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [3:0] CMD_STATUS = 4'h0;
  localparam logic [3:0] CMD_DATA   = 4'h1;
  localparam logic [3:0] CMD_COUNT  = 4'h2;
  localparam logic [3:0] CMD_FLUSH  = 4'h3;

  typedef enum logic [1:0] {IDLE, RESP, RELEASE} state_e;

  logic [3:0]             cmd_sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] clk_sync_q, en_sync_q;
  logic                   clk_prev_q;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) cmd_sync_q[i] <= '0;
      clk_sync_q <= '0;
      en_sync_q  <= '0;
      clk_prev_q <= 1'b0;
    end else begin
      cmd_sync_q[0] <= raspi_cmd;
      clk_sync_q[0] <= raspi_clk;
      en_sync_q[0]  <= raspi_en;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        cmd_sync_q[i] <= cmd_sync_q[i-1];
        clk_sync_q[i] <= clk_sync_q[i-1];
        en_sync_q[i]  <= en_sync_q[i-1];
      end
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  logic [3:0] cmd_s;
  logic       clk_s, en_s, strobe_rise;
  assign cmd_s       = cmd_sync_q[SYNC_STAGES-1];
  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign en_s        = en_sync_q[SYNC_STAGES-1];
  assign strobe_rise = clk_s & ~clk_prev_q;

  state_e          state_q;
  logic [7:0]      data_q;
  logic            ack_q, underflow_q, bad_cmd_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]   count_q, count_d;

  logic decode, is_flush, empty, full, pop, wr;
  assign decode     = (state_q == IDLE) && strobe_rise && en_s;
  assign is_flush   = decode && (cmd_s == CMD_FLUSH);
  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign pop        = decode && (cmd_s == CMD_DATA) && !empty;
  assign load_ready = !full && !is_flush;
  assign wr         = load_valid && load_ready;

  logic [7:0] resp_d;
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    resp_d = 8'hFF;
    case (cmd_s)
      CMD_STATUS: resp_d = {underflow_q, bad_cmd_q, full, empty, 4'b0000};
      CMD_DATA:   resp_d = empty ? 8'h00 : mem_q[rd_ptr_q];
      CMD_COUNT:  resp_d = 8'(count_q);
      CMD_FLUSH:  resp_d = 8'h00;
      default:    resp_d = 8'hFF;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (is_flush)          count_d = '0;
    else if (wr && !pop)   count_d = count_q + CW'(1);
    else if (pop && !wr)   count_d = count_q - CW'(1);
  end

  // NOTE: storage array has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= load_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (is_flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (wr)  wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      end
    end
  end

  // Decode and sticky-flag updates happen only on the IDLE->RESP edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_q       <= 1'b0;
      data_q      <= 8'h00;
      underflow_q <= 1'b0;
      bad_cmd_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (decode) begin
            state_q <= RESP;
            ack_q   <= 1'b1;
            data_q  <= resp_d;
            case (cmd_s)
              CMD_STATUS: begin
                underflow_q <= 1'b0;
                bad_cmd_q   <= 1'b0;
              end
              CMD_DATA:  if (empty) underflow_q <= 1'b1;
              CMD_COUNT, CMD_FLUSH: ;
              default:   bad_cmd_q <= 1'b1;
            endcase
          end
        end
        RESP: begin
          if (!en_s || !clk_s) begin
            state_q <= RELEASE;
            ack_q   <= 1'b0;
          end
        end
        RELEASE: state_q <= IDLE;
        default: begin
          state_q <= IDLE;
          ack_q   <= 1'b0;
        end
      endcase
    end
  end

  assign raspi_data = data_q;
  assign raspi_ack  = ack_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_cdrom_link_responder.sv
// Self-checking bench for cdrom_link_responder: directed vector table, multi-cycle
// corner sequences, then random traffic against a queue-based reference model.
module tb_cdrom_link_responder;
  localparam int DEPTH = 16;
  localparam int SYNC  = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] raspi_cmd = '0;
  logic       raspi_clk = 1'b0;
  logic       raspi_en = 1'b0;
  logic [7:0] raspi_data;
  logic       raspi_ack;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic [4:0] fifo_count;

  cdrom_link_responder #(.DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .raspi_cmd(raspi_cmd), .raspi_clk(raspi_clk),
    .raspi_en(raspi_en), .raspi_data(raspi_data), .raspi_ack(raspi_ack),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: byte queue plus the two sticky flags.
  logic [7:0] model_q[$];
  bit         m_uf = 0, m_bc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_xfer(input logic [3:0] cmd, output logic [7:0] exp);
    case (cmd)
      4'h0: begin
        exp = {m_uf, m_bc, model_q.size() == DEPTH, model_q.size() == 0, 4'b0000};
        m_uf = 0;
        m_bc = 0;
      end
      4'h1: begin
        if (model_q.size() == 0) begin
          exp = 8'h00;
          m_uf = 1;
        end else exp = model_q.pop_front();
      end
      4'h2: exp = 8'(model_q.size());
      4'h3: begin
        model_q.delete();
        exp = 8'h00;
      end
      default: begin
        exp = 8'hFF;
        m_bc = 1;
      end
    endcase
  endtask

  // All tasks are entered and left just after a falling clock edge.
  task automatic do_load(input logic [7:0] d);
    load_valid = 1'b1;
    load_data  = d;
    check("load_ready", load_ready, model_q.size() < DEPTH);
    if (model_q.size() < DEPTH) model_q.push_back(d);
    @(negedge clk);
    load_valid = 1'b0;
    check("load_count", fifo_count, model_q.size());
  endtask

  task automatic xfer(input logic [3:0] cmd, output logic [7:0] data);
    int k;
    raspi_cmd = cmd;
    raspi_en  = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    raspi_clk = 1'b1;
    for (k = 0; k < 20 && !raspi_ack; k++) @(negedge clk);
    check("ack_rise", raspi_ack, 1);
    check("ack_latency", k, SYNC + 1);
    data = raspi_data;
    raspi_clk = 1'b0;
    for (k = 0; k < 20 && raspi_ack; k++) @(negedge clk);
    check("ack_fall", raspi_ack, 0);
    raspi_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
  endtask

  task automatic xfer_check(input logic [3:0] cmd, input string name);
    logic [7:0] exp, got;
    model_xfer(cmd, exp);
    xfer(cmd, got);
    check(name, got, exp);
    check({name, "_count"}, fifo_count, model_q.size());
  endtask

  typedef struct {
    bit         is_load;
    logic [7:0] val;
    logic [7:0] exp_data;
    int         exp_count;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got, exp;
    int k, acks;

    vecs.push_back('{1, 8'hA1, 8'h00, 1});
    vecs.push_back('{1, 8'hB2, 8'h00, 2});
    vecs.push_back('{1, 8'hC3, 8'h00, 3});
    vecs.push_back('{0, 8'h01, 8'hA1, 2});
    vecs.push_back('{0, 8'h01, 8'hB2, 1});
    vecs.push_back('{0, 8'h01, 8'hC3, 0});
    vecs.push_back('{0, 8'h01, 8'h00, 0});
    vecs.push_back('{0, 8'h00, 8'h90, 0});
    vecs.push_back('{0, 8'h00, 8'h10, 0});
    vecs.push_back('{0, 8'h07, 8'hFF, 0});
    vecs.push_back('{0, 8'h00, 8'h50, 0});
    vecs.push_back('{0, 8'h02, 8'h00, 0});
    vecs.push_back('{1, 8'h5A, 8'h00, 1});
    vecs.push_back('{1, 8'h6B, 8'h00, 2});
    vecs.push_back('{0, 8'h02, 8'h02, 2});
    vecs.push_back('{0, 8'h03, 8'h00, 0});
    vecs.push_back('{0, 8'h00, 8'h10, 0});
    vecs.push_back('{0, 8'h01, 8'h00, 0});
    vecs.push_back('{0, 8'h00, 8'h90, 0});

    // Reset state
    #1;
    check("rst_ack", raspi_ack, 0);
    check("rst_data", raspi_data, 8'h00);
    check("rst_count", fifo_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_load_ready", load_ready, 1);

    // Directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].is_load) begin
        do_load(vecs[i].val);
      end else begin
        model_xfer(vecs[i].val[3:0], exp);
        xfer(vecs[i].val[3:0], got);
        check($sformatf("vec%0d_data", i), got, vecs[i].exp_data);
      end
      check($sformatf("vec%0d_count", i), fifo_count, vecs[i].exp_count);
    end

    // Fill to full, drop the 17th byte, STATUS shows full
    for (int i = 0; i < DEPTH; i++) do_load(8'(i * 17 + 3));
    check("full_ready", load_ready, 0);
    check("full_count", fifo_count, DEPTH);
    do_load(8'h77);
    check("drop_count", fifo_count, DEPTH);
    xfer_check(4'h0, "full_status");

    // Pop while the producer is waiting: refilled to DEPTH on the next cycle
    load_valid = 1'b1;
    load_data  = 8'hEE;
    model_xfer(4'h1, exp);
    xfer(4'h1, got);
    load_valid = 1'b0;
    model_q.push_back(8'hEE);
    check("refill_data", got, exp);
    check("refill_count", fifo_count, DEPTH);

    // Write and pop on the very same edge keep the count unchanged
    xfer_check(4'h1, "pre_pop");
    raspi_cmd = 4'h1;
    raspi_en  = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    raspi_clk = 1'b1;
    repeat (SYNC) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'h3C;
    check("same_edge_ready", load_ready, 1);
    @(negedge clk);
    load_valid = 1'b0;
    check("same_edge_ack", raspi_ack, 1);
    model_xfer(4'h1, exp);
    model_q.push_back(8'h3C);
    check("same_edge_data", raspi_data, exp);
    check("same_edge_count", fifo_count, DEPTH - 1);
    raspi_clk = 1'b0;
    for (k = 0; k < 20 && raspi_ack; k++) @(negedge clk);
    check("same_edge_ack_fall", raspi_ack, 0);
    raspi_en = 1'b0;
    repeat (SYNC + 2) @(negedge clk);
    for (int i = 0; i < DEPTH - 1; i++) xfer_check(4'h1, "drain");

    // Strobe with en low is ignored
    do_load(8'h42);
    raspi_cmd = 4'h1;
    raspi_clk = 1'b1;
    acks = 0;
    repeat (8) begin
      @(negedge clk);
      if (raspi_ack) acks++;
    end
    check("en_low_acks", acks, 0);
    check("en_low_count", fifo_count, 1);
    raspi_clk = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    // en dropped in RESP: ack falls within SYNC+1 edges, pop is kept
    raspi_en = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    raspi_clk = 1'b1;
    for (k = 0; k < 20 && !raspi_ack; k++) @(negedge clk);
    check("en_drop_ack_rise", raspi_ack, 1);
    model_xfer(4'h1, exp);
    check("en_drop_data", raspi_data, exp);
    raspi_en = 1'b0;
    for (k = 0; k < 20 && raspi_ack; k++) @(negedge clk);
    check("en_drop_ack_fall", raspi_ack, 0);
    check("en_drop_edges_ok", k <= SYNC + 1, 1);
    check("en_drop_count", fifo_count, 0);
    raspi_clk = 1'b0;
    repeat (SYNC + 2) @(negedge clk);

    // Reset during RESP with five bytes queued
    for (int i = 0; i < 5; i++) do_load(8'(8'h10 + i));
    raspi_cmd = 4'h1;
    raspi_en  = 1'b1;
    repeat (SYNC + 1) @(negedge clk);
    raspi_clk = 1'b1;
    for (k = 0; k < 20 && !raspi_ack; k++) @(negedge clk);
    check("rst_mid_ack_rise", raspi_ack, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ack", raspi_ack, 0);
    check("rst_mid_count", fifo_count, 0);
    raspi_clk = 1'b0;
    raspi_en  = 1'b0;
    model_q.delete();
    m_uf = 0;
    m_bc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_data", raspi_data, 8'h00);
    check("rst_mid_ready", load_ready, 1);
    xfer(4'h2, got);
    check("rst_mid_count_cmd", got, 8'h00);

    // Random traffic against the model
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        do_load(8'($urandom));
      end else begin
        k = $urandom_range(0, 8);
        xfer_check(k == 8 ? 4'hC : 4'(k), "rand_xfer");
      end
    end
    xfer_check(4'h0, "rand_final_status");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
